// File: rtl/switch_unit.sv
// switch_unit
//   2x2 crossbar cell of the PN96 permutation network. Routes two words
//   straight (ctrl=0) or crossed (ctrl=1). With PIPE=1 the routed words are
//   registered and held while in_valid is low, so idle lanes do not toggle.
//   With PIPE=0 the cell is purely combinational.
//
// Parameters
//   WIDTH     : data word width
//   PIPE      : 1 = registered outputs, 0 = combinational outputs
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in1, in2  : upper / lower input words
//   ctrl      : 0 = straight, 1 = cross
//   in_valid  : inputs and ctrl meaningful this cycle
//   out1, out2: upper / lower output words
//   out_valid : outputs carry a routed word
module switch_unit #(
  parameter int WIDTH = 1,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ctrl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out_valid
);

  logic [WIDTH-1:0] route1;
  logic [WIDTH-1:0] route2;

  assign route1 = ctrl ? in2 : in1;
  assign route2 = ctrl ? in1 : in2;

  if (PIPE != 0) begin : g_pipe
    logic [WIDTH-1:0] out1_q;
    logic [WIDTH-1:0] out2_q;
    logic             valid_q;

    // Reset wins over in_valid, so a word presented under reset is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        out1_q  <= '0;
        out2_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          out1_q <= route1;
          out2_q <= route2;
        end
      end
    end

    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no effect in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign out1      = route1;
    assign out2      = route2;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_switch_unit.sv
module tb_switch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=1, PIPE=1
  logic       a_in1 = 1'b0, a_in2 = 1'b0, a_ctrl = 1'b0, a_vld = 1'b0;
  logic       a_out1, a_out2, a_ov;
  // WIDTH=8, PIPE=1
  logic [7:0] b_in1 = '0, b_in2 = '0;
  logic       b_ctrl = 1'b0, b_vld = 1'b0;
  logic [7:0] b_out1, b_out2;
  logic       b_ov;
  // WIDTH=8, PIPE=0
  logic [7:0] c_in1 = '0, c_in2 = '0;
  logic       c_ctrl = 1'b0, c_vld = 1'b0;
  logic [7:0] c_out1, c_out2;
  logic       c_ov;

  switch_unit #(.WIDTH(1), .PIPE(1)) dut_a (
    .clk(clk), .rst(rst), .in1(a_in1), .in2(a_in2), .ctrl(a_ctrl),
    .in_valid(a_vld), .out1(a_out1), .out2(a_out2), .out_valid(a_ov));

  switch_unit #(.WIDTH(8), .PIPE(1)) dut_b (
    .clk(clk), .rst(rst), .in1(b_in1), .in2(b_in2), .ctrl(b_ctrl),
    .in_valid(b_vld), .out1(b_out1), .out2(b_out2), .out_valid(b_ov));

  switch_unit #(.WIDTH(8), .PIPE(0)) dut_c (
    .clk(clk), .rst(rst), .in1(c_in1), .in2(c_in2), .ctrl(c_ctrl),
    .in_valid(c_vld), .out1(c_out1), .out2(c_out2), .out_valid(c_ov));

  // Scoreboards: {out1, out2} expected, pushed at drive, popped at output.
  logic [1:0]  qa[$];
  logic [15:0] qb[$];
  logic [15:0] b_hold = '0;  // model of the held output register of dut_b

  // One cycle on dut_a; checks output one cycle later against the queue.
  task automatic step_a(input logic i1, input logic i2, input logic c,
                        input logic v, input string name);
    logic [1:0] e;
    a_in1 = i1; a_in2 = i2; a_ctrl = c; a_vld = v;
    if (v && !rst) qa.push_back(c ? {i2, i1} : {i1, i2});
    @(posedge clk); #1;
    n_cmp++;
    if (a_ov !== (v && !rst)) begin
      n_err++;
      $display("FAIL %s valid: got %b expected %b", name, a_ov, v && !rst);
    end
    if (a_ov === 1'b1 && qa.size() > 0) begin
      e = qa.pop_front();
      n_cmp++;
      if ({a_out1, a_out2} !== e) begin
        n_err++;
        $display("FAIL %s data: got %b%b expected %b", name, a_out1, a_out2, e);
      end
    end
  endtask

  // One cycle on dut_b; outputs are compared every cycle against the hold model.
  task automatic step_b(input logic [7:0] i1, input logic [7:0] i2,
                        input logic c, input logic v, input string name);
    logic exp_v;
    b_in1 = i1; b_in2 = i2; b_ctrl = c; b_vld = v;
    if (v && !rst) qb.push_back(c ? {i2, i1} : {i1, i2});
    exp_v = v && !rst;
    @(posedge clk); #1;
    if (rst) b_hold = '0;
    else if (exp_v && qb.size() > 0) b_hold = qb.pop_front();
    n_cmp++;
    if (b_ov !== exp_v) begin
      n_err++;
      $display("FAIL %s valid: got %b expected %b", name, b_ov, exp_v);
    end
    n_cmp++;
    if ({b_out1, b_out2} !== b_hold) begin
      n_err++;
      $display("FAIL %s data: got %h_%h expected %h", name, b_out1, b_out2, b_hold);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b_in1 = 8'hA5; b_in2 = 8'h3C; b_ctrl = 1'b1; b_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_a(1'b1, 1'b0, 1'b0, 1'b1, "reset_a");
      n_cmp++;
      if ({b_out1, b_out2, b_ov} !== 17'h0) begin
        n_err++;
        $display("FAIL reset_b: got %h_%h v=%b expected 0_0 v=0", b_out1, b_out2, b_ov);
      end
    end
    b_vld = 1'b0;
    rst = 1'b0;
    step_a(1'b1, 1'b0, 1'b0, 1'b1, "first_after_reset");
  endtask

  task automatic test_straight();
    step_a(1'b0, 1'b1, 1'b0, 1'b1, "straight");
  endtask

  task automatic test_cross();
    step_a(1'b0, 1'b1, 1'b1, 1'b1, "cross");
  endtask

  task automatic test_random_ctrl();
    logic c;
    for (int i = 0; i < 200; i++) begin
      c = 1'($urandom_range(0, 1));
      step_a(1'b0, 1'b1, c, 1'b1, "random_ctrl");
    end
    step_a(1'b0, 1'b0, 1'b0, 1'b0, "random_idle");
  endtask

  task automatic test_hold();
    step_b(8'hA5, 8'h3C, 1'b1, 1'b1, "hold_load");
    n_cmp++;
    if ({b_out1, b_out2} !== 16'h3CA5) begin
      n_err++;
      $display("FAIL hold_load_const: got %h_%h expected 3c_a5", b_out1, b_out2);
    end
    for (int i = 0; i < 3; i++) step_b(8'hFF, 8'h00, 1'b0, 1'b0, "hold_idle");
    n_cmp++;
    if ({b_out1, b_out2} !== 16'h3CA5) begin
      n_err++;
      $display("FAIL hold_const: got %h_%h expected 3c_a5", b_out1, b_out2);
    end
  endtask

  task automatic test_equal_inputs();
    step_b(8'h5A, 8'h5A, 1'b0, 1'b1, "equal_straight");
    step_b(8'h5A, 8'h5A, 1'b1, 1'b1, "equal_cross");
  endtask

  task automatic test_reset_midstream();
    step_b(8'h11, 8'h22, 1'b0, 1'b1, "mid_pre");
    rst = 1'b1;
    step_b(8'h33, 8'h44, 1'b1, 1'b1, "mid_in_reset");
    rst = 1'b0;
    step_b(8'h55, 8'h66, 1'b0, 1'b0, "mid_after_idle");
    step_b(8'h77, 8'h88, 1'b1, 1'b1, "mid_first");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++)
      step_b(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), "b2b");
    step_b(8'h00, 8'h00, 1'b0, 1'b0, "b2b_drain");
  endtask

  task automatic test_comb();
    c_in1 = 8'h12; c_in2 = 8'h34; c_ctrl = 1'b0; c_vld = 1'b1;
    #1; n_cmp++;
    if ({c_out1, c_out2, c_ov} !== {16'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL comb_straight: got %h_%h v=%b expected 12_34 v=1", c_out1, c_out2, c_ov);
    end
    c_ctrl = 1'b1;
    #1; n_cmp++;
    if ({c_out1, c_out2, c_ov} !== {16'h3412, 1'b1}) begin
      n_err++;
      $display("FAIL comb_cross: got %h_%h v=%b expected 34_12 v=1", c_out1, c_out2, c_ov);
    end
    c_vld = 1'b0;
    #1; n_cmp++;
    if ({c_out1, c_out2, c_ov} !== {16'h3412, 1'b0}) begin
      n_err++;
      $display("FAIL comb_invalid: got %h_%h v=%b expected 34_12 v=0", c_out1, c_out2, c_ov);
    end
    c_ctrl = 1'b0;
    #1; n_cmp++;
    if ({c_out1, c_out2} !== 16'h1234) begin
      n_err++;
      $display("FAIL comb_back: got %h_%h expected 12_34", c_out1, c_out2);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_straight();
    test_cross();
    test_random_ctrl();
    test_hold();
    test_equal_inputs();
    test_reset_midstream();
    test_back_to_back();
    test_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
